// File: rtl/mac_array_seq.sv
// Self-sequencing weight-stationary MAC array: command FSM, input handshake, diagonal skew and drain.
// Define MAC_SEQ_PERF_EN to add the perf_busy_o / perf_bubble_o saturating counters.
module mac_array_seq #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned row     = 8,
    parameter int unsigned len_bw  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_op_i,
    input  logic [len_bw-1:0]      cmd_len_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [row*bw-1:0]      in_data_i,
    input  logic [psum_bw*col-1:0] in_n_i,
    output logic [psum_bw*col-1:0] out_s_o,
    output logic [col-1:0]         valid_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   kernel_ok_o,
`ifdef MAC_SEQ_PERF_EN
    output logic [31:0]            perf_busy_o,
    output logic [31:0]            perf_bubble_o,
`endif
    output logic                   err_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StExec, StDrain} state_e;

    localparam int unsigned DrainLen = row + col;
    localparam int unsigned DrainBw  = $clog2(DrainLen + 1);

    state_e              state_q, state_d;
    logic [len_bw-1:0]   cnt_q, cnt_d, tgt_q, tgt_d;
    logic [DrainBw-1:0]  drain_q, drain_d;
    logic                is_load_q, is_load_d, done_q, done_d;
    logic                kok_q, kok_d, err_q, err_d;
    logic                accept;

    assign cmd_ready_o = (state_q == StIdle);
    assign in_ready_o  = (state_q == StLoad) || (state_q == StExec);
    assign busy_o      = (state_q != StIdle);
    assign accept      = in_valid_i & in_ready_o;
    assign done_o      = done_q;
    assign kernel_ok_o = kok_q;
    assign err_o       = err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        drain_d   = drain_q;
        is_load_d = is_load_q;
        kok_d     = kok_q;
        err_d     = err_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    cnt_d   = '0;
                    drain_d = '0;
                    if (!cmd_op_i) begin
                        state_d   = StLoad;
                        tgt_d     = len_bw'(col);
                        is_load_d = 1'b1;
                    end else if (!kok_q) begin
                        err_d = 1'b1;
                    end else begin
                        is_load_d = 1'b0;
                        tgt_d     = cmd_len_i;
                        state_d   = (cmd_len_i == '0) ? StDrain : StExec;
                    end
                end
            end
            StLoad, StExec: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == tgt_q) state_d = StDrain;
                end
            end
            StDrain: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DrainBw'(DrainLen - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (is_load_q) kok_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            tgt_q     <= '0;
            drain_q   <= '0;
            is_load_q <= 1'b0;
            done_q    <= 1'b0;
            kok_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            drain_q   <= drain_d;
            is_load_q <= is_load_d;
            done_q    <= done_d;
            kok_q     <= kok_d;
            err_q     <= err_d;
        end
    end

    // Instruction skew: entry 0 is the injection register feeding row 0; entry k feeds row k.
    logic [1:0]    sk_inst_q [row];
    logic [1:0]    row_inst  [row];
    logic [bw-1:0] row_act   [row];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(row); k++) sk_inst_q[k] <= 2'b00;
        end else begin
            sk_inst_q[0] <= accept ? ((state_q == StLoad) ? 2'b01 : 2'b10) : 2'b00;
            for (int k = 1; k < int'(row); k++) sk_inst_q[k] <= sk_inst_q[k-1];
        end
    end

    for (genvar r = 0; r < row; r++) begin : g_skew
        logic [bw-1:0] d_q [r+1];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int k = 0; k <= r; k++) d_q[k] <= '0;
            end else begin
                d_q[0] <= accept ? in_data_i[r*bw +: bw] : '0;
                for (int k = 1; k <= r; k++) d_q[k] <= d_q[k-1];
            end
        end
        assign row_inst[r] = sk_inst_q[r];
        assign row_act[r]  = d_q[r];
    end

    logic [bw-1:0]      w_w   [row][col];
    logic [bw-1:0]      act_w [row][col];
    logic [1:0]         ins_w [row][col];
    logic [psum_bw-1:0] ps_w  [row][col];

    for (genvar r = 0; r < row; r++) begin : g_row
        for (genvar c = 0; c < col; c++) begin : g_col
            logic [bw-1:0]      a_in, w_nxt, w_q, act_q;
            logic [1:0]         i_in, inst_q;
            logic [psum_bw-1:0] p_in, ps_q;
            logic signed [2*bw:0] prod;

            if (c == 0) begin : g_west
                assign a_in = row_act[r];
                assign i_in = row_inst[r];
            end else begin : g_link
                assign a_in = act_w[r][c-1];
                assign i_in = ins_w[r][c-1];
            end
            if (r == 0) begin : g_top
                assign p_in = in_n_i[c*psum_bw +: psum_bw];
            end else begin : g_north
                assign p_in = ps_w[r-1][c];
            end
            // LOAD shifts the row's weights westward, so load vector k settles in column k.
            if (c == col - 1) begin : g_wlast
                assign w_nxt = row_act[r];
            end else begin : g_wshift
                assign w_nxt = w_w[r][c+1];
            end

            assign prod = $signed(w_q) * $signed({1'b0, a_in});

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    w_q    <= '0;
                    act_q  <= '0;
                    inst_q <= 2'b00;
                    ps_q   <= '0;
                end else begin
                    act_q  <= a_in;
                    inst_q <= i_in;
                    ps_q   <= p_in + ((i_in == 2'b10) ?
                              {{(psum_bw-2*bw-1){prod[2*bw]}}, prod} : '0);
                    if (row_inst[r] == 2'b01) w_q <= w_nxt;
                end
            end

            assign w_w[r][c]   = w_q;
            assign act_w[r][c] = act_q;
            assign ins_w[r][c] = inst_q;
            assign ps_w[r][c]  = ps_q;
        end
    end

    for (genvar c = 0; c < col; c++) begin : g_out
        assign out_s_o[c*psum_bw +: psum_bw] = ps_w[row-1][c];
        assign valid_o[c]                    = (ins_w[row-1][c] == 2'b10);
    end

`ifdef MAC_SEQ_PERF_EN
    logic [31:0] perf_busy_q, perf_bubble_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_busy_q   <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (busy_o && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 1'b1;
            if (in_ready_o && !in_valid_i && (perf_bubble_q != '1)) begin
                perf_bubble_q <= perf_bubble_q + 1'b1;
            end
        end
    end

    assign perf_busy_o   = perf_busy_q;
    assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_mac_array_seq.sv
// Scoreboard bench for mac_array_seq: stimulus pushes expected psum vectors, a monitor pops on valid.
module tb_mac_array_seq;
    localparam int BW = 4, PB = 16, COL = 8, ROW = 8, LB = 8;

    logic              clk = 1'b0, rst_n;
    logic              cmd_valid, cmd_ready, cmd_op, in_valid, in_ready;
    logic [LB-1:0]     cmd_len;
    logic [ROW*BW-1:0] in_data;
    logic [PB*COL-1:0] in_n, out_s;
    logic [COL-1:0]    valid;
    logic              busy, done, kernel_ok, err;
`ifdef MAC_SEQ_PERF_EN
    logic [31:0]       perf_busy, perf_bubble;
`endif

    mac_array_seq dut (
        .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_n_i(in_n), .out_s_o(out_s), .valid_o(valid), .busy_o(busy),
        .done_o(done), .kernel_ok_o(kernel_ok),
`ifdef MAC_SEQ_PERF_EN
        .perf_busy_o(perf_busy), .perf_bubble_o(perf_bubble),
`endif
        .err_o(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    logic [PB*COL-1:0] exp_q[$];
    logic [PB*COL-1:0] got_vec[$];
    int                col_cnt[COL];
    logic [BW-1:0]     wt[COL][ROW];
    logic [PB-1:0]     bias_v = '0;
    bit                hand_en = 1'b0;
    int                last_acc, cmd_cyc, done_cyc, feed_it;
    int                exp_busy = 0, exp_bubble = 0;

    assign in_n = {COL{bias_v}};

    function automatic logic [ROW*BW-1:0] wt_vec(input int sel, input int k);
        logic [ROW*BW-1:0] v;
        for (int r = 0; r < ROW; r++) v[r*BW +: BW] = (sel == 0) ? BW'((k + r) & 15) : '0;
        return v;
    endfunction

    function automatic logic [ROW*BW-1:0] act_vec(input int sel, input int j);
        logic [ROW*BW-1:0] v;
        for (int r = 0; r < ROW; r++) v[r*BW +: BW] = (sel == 0) ? 4'h1 : BW'((3*j + r + 1) & 15);
        return v;
    endfunction

    // Golden dot product: column c holds load vector c; signed weights, unsigned acts, 16-bit wrap.
    function automatic logic [PB*COL-1:0] model(input logic [ROW*BW-1:0] acts);
        logic [PB*COL-1:0] v;
        logic [PB-1:0]     s;
        int                wv, av;
        for (int c = 0; c < COL; c++) begin
            s = bias_v;
            for (int r = 0; r < ROW; r++) begin
                wv = $signed(wt[c][r]);
                av = int'(acts[r*BW +: BW]);
                s  = s + PB'(wv * av);
            end
            v[c*PB +: PB] = s;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        logic [PB*COL-1:0] e;
        if (rst_n) begin
            if (valid[0]) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid cyc=%0d got valid=%b required none", cyc, valid);
                end else begin
                    got_vec.push_back(exp_q.pop_front());
                end
            end
            for (int c = 0; c < COL; c++) begin
                if (valid[c]) begin
                    total++;
                    if (col_cnt[c] < got_vec.size()) begin
                        e = got_vec[col_cnt[c]];
                        if (out_s[c*PB +: PB] !== e[c*PB +: PB]) begin
                            bad++;
                            $display("FAIL psum col=%0d vec=%0d got=%0d required=%0d", c,
                                     col_cnt[c], out_s[c*PB +: PB], e[c*PB +: PB]);
                        end else if (hand_en && out_s[c*PB +: PB] != 16'd100) begin
                            bad++;
                            $display("FAIL bias col=%0d got=%0d required=100", c, out_s[c*PB +: PB]);
                        end
                    end else begin
                        bad++;
                        $display("FAIL orphan_valid col=%0d got valid required none", c);
                    end
                    col_cnt[c]++;
                end
            end
        end
    end

    task automatic sb_check(input string nm);
        int miss = exp_q.size();
        for (int c = 0; c < COL; c++) if (col_cnt[c] != got_vec.size()) miss++;
        chk({"sb_", nm}, miss, 0);
        exp_q.delete();
        got_vec.delete();
        for (int c = 0; c < COL; c++) col_cnt[c] = 0;
    endtask

    task automatic cmd(input bit op, input int len);
        chk("cmd_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = LB'(len); cmd_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input int n, input bit is_exec, input bit bub, input int sel);
        int i = 0, it = 0;
        logic [ROW*BW-1:0] d;
        while (i < n && it < 100) begin
            d        = is_exec ? act_vec(sel, i) : wt_vec(sel, i);
            in_valid = bub ? (it % 2 == 0) : 1'b1;
            in_data  = in_valid ? d : {ROW{4'hA}};
            if (!in_valid) exp_bubble++;
            if (in_valid && in_ready) begin
                last_acc = cyc;
                if (is_exec) exp_q.push_back(model(d));
                else for (int r = 0; r < ROW; r++) wt[i][r] = d[r*BW +: BW];
                i++;
            end
            it++;
            exp_busy++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
        feed_it  = it;
        chk("feed_accepts", i, n);
    endtask

    task automatic wait_done(input int ref_cyc, input string nm);
        int k = 0;
        while (!done && k < 64) begin
            @(negedge clk);
            k++;
        end
        done_cyc = cyc;
        chk(nm, done_cyc - ref_cyc, ROW + COL + 1);
        exp_busy += ROW + COL;
        @(negedge clk);
        chk({nm, "_pulse"}, int'({done, busy}), 0);
    endtask

    int  d0, d1;
    bit  quiet;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_len = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_outs", int'(valid != '0 || out_s != '0), 0);
        chk("rst_flags", int'({done, kernel_ok, err}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // EXEC with no kernel: error only, FSM never leaves idle.
        cmd(1'b1, 4);
        quiet = 1'b1;
        repeat (20) begin
            if (busy || done) quiet = 1'b0;
            @(negedge clk);
        end
        chk("noload_quiet", int'(quiet), 1);
        chk("noload_err", int'(err), 1);
        sb_check("noload");

        // LOAD then EXEC len=4, all-ones acts.
        cmd(1'b0, 0);
        feed(8, 1'b0, 1'b0, 0);
        wait_done(last_acc, "load_done_gap");
        chk("kernel_ok", int'(kernel_ok), 1);
        cmd(1'b1, 4);
        feed(4, 1'b1, 1'b0, 0);
        wait_done(last_acc, "exec4_done_gap");
        sb_check("exec4");

        // EXEC len=6 without, then with, alternating bubbles.
        cmd(1'b1, 6);
        d0 = cmd_cyc;
        feed(6, 1'b1, 1'b0, 1);
        wait_done(last_acc, "exec6_done_gap");
        d0 = done_cyc - d0;
        sb_check("exec6");
        cmd(1'b1, 6);
        d1 = cmd_cyc;
        feed(6, 1'b1, 1'b1, 1);
        chk("bubble_span", feed_it, 11);
        wait_done(last_acc, "bub_done_gap");
        d1 = done_cyc - d1;
        chk("bubble_delay", d1 - d0, 5);
        sb_check("bubble");

        // EXEC len=0 goes straight to DRAIN.
        cmd(1'b1, 0);
        wait_done(cmd_cyc, "len0_done_gap");
        sb_check("len0");

        // Zero weights with bias 100.
        cmd(1'b0, 0);
        feed(8, 1'b0, 1'b0, 1);
        wait_done(last_acc, "load0_done_gap");
        bias_v  = 16'd100;
        hand_en = 1'b1;
        cmd(1'b1, 3);
        feed(3, 1'b1, 1'b0, 1);
        wait_done(last_acc, "bias_done_gap");
        sb_check("bias");
        hand_en = 1'b0;
        bias_v  = '0;
`ifdef MAC_SEQ_PERF_EN
        chk("perf_bubble", int'(perf_bubble), exp_bubble);
        chk("perf_busy", int'(perf_busy), exp_busy);
`endif
        chk("err_sticky", int'(err), 1);

        // Reset in the middle of an EXEC.
        cmd(1'b1, 8);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = act_vec(1, k);
            @(negedge clk);
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_flags", int'({done, kernel_ok, err}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_ready", int'(cmd_ready), 1);
        chk("midrst_in_ready", int'(in_ready), 0);
        cmd(1'b1, 2);
        @(negedge clk);
        chk("midrst_need_reload", int'({err, busy}), 2);
        sb_check("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
